// File: rtl/seq_decoder.sv
// picoMIPS instruction decoder / control unit: combinational decode plus a
// multiply stall, debounced handshake waits with optional timeout, and illegal-opcode flagging.
module seq_decoder #(
    parameter int OPCODE_SIZE     = 3,
    parameter int ALU_CODE_SIZE   = 3,
    parameter int NUM_HS          = 2,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int MUL_LATENCY     = 2,
    parameter int TIMEOUT_CYCLES  = 0,
    localparam int SEL_W = (NUM_HS > 1) ? $clog2(NUM_HS) : 1
) (
    input  logic                     clk,
    input  logic                     nReset,
    input  logic [OPCODE_SIZE-1:0]   opcode,
    input  logic [SEL_W-1:0]         hs_sel,
    input  logic [NUM_HS-1:0]        hs_in,
    output logic                     pc_inc,
    output logic [ALU_CODE_SIZE-1:0] alu_func,
    output logic                     imm,
    output logic                     w,
    output logic                     stall,
    output logic                     timeout,
    output logic                     illegal,
    output logic [1:0]               dbg_state   // 0 RUN, 1 MUL_STALL, 2 WAIT
);

    localparam int OP_NOP   = 0;
    localparam int OP_ADD   = 1;
    localparam int OP_ADDI  = 2;
    localparam int OP_MULT  = 3;
    localparam int OP_MULTI = 4;
    localparam int OP_COPY  = 5;
    localparam int OP_WLD0  = 6;
    localparam int OP_WLD1  = 7;

    localparam int DCW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int MCW = (MUL_LATENCY > 0) ? $clog2(MUL_LATENCY + 1) : 1;
    // With the timeout disabled the wait counter only needs to saturate, so any width works.
    localparam int WCW = (TIMEOUT_CYCLES == 0) ? 8 :
                         ((TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1);

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        MUL_STALL = 2'd1,
        WAIT      = 2'd2
    } state_t;

    state_t                   state_q, state_d;
    logic [OPCODE_SIZE-1:0]   op_q, op_d;
    logic [SEL_W-1:0]         sel_q, sel_d;
    logic [MCW-1:0]           mul_cnt_q, mul_cnt_d;
    logic [WCW-1:0]           wait_cnt_q, wait_cnt_d;
    logic [NUM_HS-1:0]        sync_q [SYNC_STAGES];
    logic [NUM_HS-1:0]        sync_d [SYNC_STAGES];
    logic [DCW-1:0]           deb_cnt_q [NUM_HS];
    logic [DCW-1:0]           deb_cnt_d [NUM_HS];
    logic [NUM_HS-1:0]        hs_clean_q, hs_clean_d;
    logic [NUM_HS-1:0]        sync_out;

    logic [OPCODE_SIZE-1:0]   op_act;
    logic [SEL_W-1:0]         sel_act;
    int                       op_int;
    logic                     sel_ok;
    logic                     sel_bit;
    logic                     hs_match;

    // Input conditioning: synchroniser chain, then a per-channel run-length debouncer.
    always_comb begin
        sync_d[0] = hs_in;
        for (int k = 1; k < SYNC_STAGES; k++) begin
            sync_d[k] = sync_q[k-1];
        end
        sync_out   = sync_q[SYNC_STAGES-1];
        hs_clean_d = hs_clean_q;
        for (int i = 0; i < NUM_HS; i++) begin
            deb_cnt_d[i] = '0;
            if (sync_out[i] != hs_clean_q[i]) begin
                if (deb_cnt_q[i] == DCW'(DEBOUNCE_CYCLES - 1)) begin
                    hs_clean_d[i] = ~hs_clean_q[i];
                end else begin
                    deb_cnt_d[i] = deb_cnt_q[i] + 1'b1;
                end
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        sel_d      = sel_q;
        mul_cnt_d  = mul_cnt_q;
        wait_cnt_d = wait_cnt_q;
        pc_inc     = 1'b0;
        w          = 1'b0;
        stall      = 1'b0;
        timeout    = 1'b0;
        illegal    = 1'b0;
        alu_func   = '0;

        op_act  = (state_q == RUN) ? opcode : op_q;
        sel_act = (state_q == RUN) ? hs_sel : sel_q;
        op_int  = int'(op_act);
        sel_ok  = int'(sel_act) < NUM_HS;
        sel_bit = 1'b0;
        for (int i = 0; i < NUM_HS; i++) begin
            if (int'(sel_act) == i) sel_bit = hs_clean_q[i];
        end
        hs_match = sel_ok && (sel_bit == (op_int == OP_WLD1));
        imm      = (op_int == OP_ADDI) || (op_int == OP_MULTI);

        case (state_q)
            RUN: begin
                case (op_int)
                    OP_NOP: pc_inc = 1'b1;
                    OP_ADD, OP_ADDI, OP_COPY: begin
                        pc_inc = 1'b1;
                        w      = 1'b1;
                    end
                    OP_MULT, OP_MULTI: begin
                        if (MUL_LATENCY == 0) begin
                            pc_inc = 1'b1;
                            w      = 1'b1;
                        end else begin
                            // The issue cycle is the first stall cycle, so load one less.
                            stall     = 1'b1;
                            state_d   = MUL_STALL;
                            op_d      = opcode;
                            sel_d     = hs_sel;
                            mul_cnt_d = MCW'(MUL_LATENCY - 1);
                        end
                    end
                    OP_WLD0, OP_WLD1: begin
                        if (!sel_ok) begin
                            illegal = 1'b1;
                            pc_inc  = 1'b1;
                        end else if (hs_match) begin
                            pc_inc = 1'b1;
                            w      = 1'b1;
                        end else begin
                            stall      = 1'b1;
                            state_d    = WAIT;
                            op_d       = opcode;
                            sel_d      = hs_sel;
                            wait_cnt_d = '0;
                        end
                    end
                    default: begin
                        illegal = 1'b1;
                        pc_inc  = 1'b1;
                    end
                endcase
            end
            MUL_STALL: begin
                if (mul_cnt_q == '0) begin
                    w       = 1'b1;
                    pc_inc  = 1'b1;
                    state_d = RUN;
                end else begin
                    stall     = 1'b1;
                    mul_cnt_d = mul_cnt_q - 1'b1;
                end
            end
            WAIT: begin
                if (hs_match) begin
                    w       = 1'b1;
                    pc_inc  = 1'b1;
                    state_d = RUN;
                end else if ((TIMEOUT_CYCLES > 0) &&
                             (wait_cnt_q == WCW'(TIMEOUT_CYCLES - 1))) begin
                    timeout = 1'b1;
                    pc_inc  = 1'b1;
                    state_d = RUN;
                end else begin
                    stall = 1'b1;
                    if (wait_cnt_q != '1) wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            default: state_d = RUN;
        endcase

        // Reset forces every output low even though decode is combinational.
        if (!nReset) begin
            pc_inc  = 1'b0;
            w       = 1'b0;
            imm     = 1'b0;
            stall   = 1'b0;
            timeout = 1'b0;
            illegal = 1'b0;
        end else begin
            alu_func = op_act[ALU_CODE_SIZE-1:0];
        end
    end

    assign dbg_state = state_q;

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
            for (int i = 0; i < NUM_HS; i++) deb_cnt_q[i] <= '0;
            hs_clean_q <= '0;
            state_q    <= RUN;
            op_q       <= '0;
            sel_q      <= '0;
            mul_cnt_q  <= '0;
            wait_cnt_q <= '0;
        end else begin
            sync_q     <= sync_d;
            deb_cnt_q  <= deb_cnt_d;
            hs_clean_q <= hs_clean_d;
            state_q    <= state_d;
            op_q       <= op_d;
            sel_q      <= sel_d;
            mul_cnt_q  <= mul_cnt_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

endmodule

// File: doc/seq_decoder.md
Name: seq_decoder

Overview:
Next-generation picoMIPS instruction decoder/control unit, sitting between the program memory opcode field and the PC, ALU, immediate mux and register file.
- Same instruction set: NOP, ADD, ADDI, MULT, MULTI, COPY, WLD0, WLD1, using the codes in opcodes.sv.
- Adds sequential control: multi-cycle multiply stall and synchronised, debounced handshake inputs on NUM_HS channels.
- Adds a wait timeout and illegal-instruction flagging.

Parameters:
OPCODE_SIZE, 3, opcode field width; codes above the defined set are illegal.
ALU_CODE_SIZE, 3, alu_func width; alu_func = opcode[ALU_CODE_SIZE-1:0].
NUM_HS, 2, number of handshake switch inputs (min 1).
SYNC_STAGES, 2, synchroniser flops per hs_in bit (min 2).
DEBOUNCE_CYCLES, 4, consecutive stable cycles needed before hs_clean changes (min 1).
MUL_LATENCY, 2, stall cycles before a MULT/MULTI write; 0 means single-cycle.
TIMEOUT_CYCLES, 0, WLD wait limit in cycles; 0 disables the timeout.

Ports:
clk  input  1  system clock, rising edge.
nReset  input  1  asynchronous active-low reset.
opcode  input  OPCODE_SIZE  opcode of current instruction.
hs_sel  input  max(1,$clog2(NUM_HS))  handshake channel selected by WLD0/WLD1.
hs_in  input  NUM_HS  raw asynchronous handshake switches.
pc_inc  output  1  PC advance enable.
alu_func  output  ALU_CODE_SIZE  ALU function code.
imm  output  1  immediate operand mux select.
w  output  1  register file write enable.
stall  output  1  high while in MUL_STALL or WAIT.
timeout  output  1  one-cycle pulse when a WLD wait is abandoned.
illegal  output  1  high for the cycle an illegal instruction is decoded.

Behaviour:
- Clock and reset: one clock, clk. Reset nReset is asynchronous, active-low.
- While nReset is low:
  - state is RUN; sync, debounce, stall and wait counters clear; hs_clean is 0.
  - pc_inc, w, imm, stall, timeout, illegal are 0; alu_func is 0.
- After reset release, outputs follow the rules below from the first clock.
- Reset asserted mid-stall or mid-wait aborts the operation immediately. No write occurs.
- Input conditioning (per channel):
  - hs_in passes through SYNC_STAGES flops.
  - hs_clean[i] toggles only after the synchronised value differs from hs_clean[i] for DEBOUNCE_CYCLES consecutive cycles; any mismatch break reloads the counter.
  - Raw-to-hs_clean latency is SYNC_STAGES + DEBOUNCE_CYCLES cycles.
- Decoding:
  - Outputs are combinational from state, the active opcode and hs_clean; no output is registered.
  - Active opcode is the opcode input in RUN, or the latched opcode in MUL_STALL/WAIT.
  - The opcode (and hs_sel) are latched on entry to MUL_STALL or WAIT; input changes are ignored until return to RUN.
- FSM states: RUN, MUL_STALL, WAIT.
- RUN:
  - NOP: pc_inc=1, w=0.
  - ADD, COPY: pc_inc=1, w=1.
  - ADDI: pc_inc=1, w=1, imm=1.
  - MULT/MULTI with MUL_LATENCY=0: as ADD/ADDI, single cycle.
  - MULT/MULTI with MUL_LATENCY>0: pc_inc=0, w=0, stall=1; go to MUL_STALL with count=MUL_LATENCY.
  - WLD0 (target 0) / WLD1 (target 1), hs_clean[hs_sel]==target: pc_inc=1, w=1, complete in the same cycle.
  - WLD0/WLD1, otherwise: pc_inc=0, w=0, stall=1; go to WAIT with wait counter cleared.
  - Illegal opcode, or WLD with hs_sel>=NUM_HS: illegal=1, treated as NOP (pc_inc=1, w=0).
- MUL_STALL:
  - Count decrements each cycle; stall=1; imm held for MULTI.
  - The cycle after count reaches 0 is the completion cycle: w=1, pc_inc=1, stall=0; go to RUN.
  - Total MULT duration is MUL_LATENCY+1 cycles, with exactly one w pulse.
- WAIT:
  - Each cycle, if hs_clean[latched hs_sel]==target: w=1, pc_inc=1, stall=0; go to RUN.
  - Else, if TIMEOUT_CYCLES>0 and the wait counter equals TIMEOUT_CYCLES-1: timeout=1, pc_inc=1, w=0, stall=0; go to RUN (instruction skipped).
  - Else: stall=1, counter increments. The counter saturates and does not wrap when the timeout is disabled.
  - Match and timeout in the same cycle: match wins (write, no timeout).
- alu_func = active_opcode[ALU_CODE_SIZE-1:0] in every state, including stalls.

Test Plan:
- Reset: hold nReset=0, opcode=ADD, hs_in=all 1 → all outputs 0. Release → ADD gives pc_inc=1, w=1, alu_func=ADD[2:0] next cycle.
- Multiply stall: MUL_LATENCY=2, opcode=MULTI, then opcode driven to junk → cycles 1-2: pc_inc=0, w=0, stall=1, imm=1; cycle 3: w=1, pc_inc=1, imm=1; alu_func stays MULTI throughout.
- Handshake wait: WLD1, hs_sel=1, hs_in[1]=0 for 10 cycles, then 1 → pc_inc=0 for the wait. w=1, pc_inc=1 exactly 2+4=6 cycles after the rise.
- Glitch rejection: 3-cycle pulse on hs_in[0] during WLD1, hs_sel=0 → hs_clean[0] stays 0, no completion.
- Timeout and race: TIMEOUT_CYCLES=5, WLD0 on a stuck-1 channel → timeout=1, w=0 in wait cycle 5. Match arriving on cycle 5 → w=1, timeout=0.
- Illegal and reset abort: OPCODE_SIZE=4, opcode=4'hF → illegal=1, pc_inc=1, w=0. Reset asserted mid-MUL_STALL → immediate outputs 0; state RUN after release.
